// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, drives the instruction-memory address and
// captures the word returned after the memory's one-cycle registered read into IR.
module instr_fetch_unit #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 16,
  parameter int START_ADDR = 0
) (
  input  logic              MClock,
  input  logic              Reset,
  input  logic              Fetch,
  input  logic              Load,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [DATA_W-1:0] MemData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] IR,
  output logic              IRValid,
  output logic              Busy,
  output logic [ADDR_W-1:0] PC,
  output logic              Wrap,
  output logic [1:0]        FsmState
);

  // Request semantics: Fetch and Load are level-sampled requests with no ready
  // handshake. Fetch is taken only in IDLE (dropped, not queued, while Busy);
  // Load is taken in every state, wins over Fetch, and aborts a fetch in flight.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    CAPT = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] PC_MAX   = {ADDR_W{1'b1}};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [DATA_W-1:0] ir_nxt;
  logic              irvalid_nxt;
  logic              wrap_nxt;

  always_ff @(posedge MClock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      PC      <= PC_RESET;
      MemAddr <= PC_RESET;
      IR      <= '0;
      IRValid <= 1'b0;
      Wrap    <= 1'b0;
    end else begin
      state   <= state_nxt;
      PC      <= pc_nxt;
      MemAddr <= pc_nxt;
      IR      <= ir_nxt;
      IRValid <= irvalid_nxt;
      Wrap    <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = PC;
    ir_nxt      = IR;
    irvalid_nxt = IRValid;
    wrap_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (Load) begin
          pc_nxt      = LoadAddr;
          irvalid_nxt = 1'b0;
        end else if (Fetch) begin
          irvalid_nxt = 1'b0;
          state_nxt   = ADDR;
        end
      end
      ADDR: begin
        // Memory registers Mem[MemAddr] on this edge; data is usable in CAPT.
        if (Load) begin
          pc_nxt    = LoadAddr;
          state_nxt = IDLE;
        end else begin
          state_nxt = CAPT;
        end
      end
      CAPT: begin
        if (Load) begin
          pc_nxt    = LoadAddr;
          state_nxt = IDLE;
        end else begin
          ir_nxt      = MemData;
          irvalid_nxt = 1'b1;
          pc_nxt      = PC + ADDR_W'(1);
          wrap_nxt    = (PC == PC_MAX);
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Busy     = (state == ADDR) || (state == CAPT);
  assign FsmState = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: registered-read memory model, expected-IR
// queue filled when fetches are issued and drained on each IRValid rise.
module tb_instr_fetch_unit;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  logic              MClock;
  logic              Reset;
  logic              Fetch;
  logic              Load;
  logic [ADDR_W-1:0] LoadAddr;
  logic [DATA_W-1:0] MemData;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] IR;
  logic              IRValid;
  logic              Busy;
  logic [ADDR_W-1:0] PC;
  logic              Wrap;
  logic [1:0]        FsmState;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .START_ADDR(0)) dut (
    .MClock   (MClock),
    .Reset    (Reset),
    .Fetch    (Fetch),
    .Load     (Load),
    .LoadAddr (LoadAddr),
    .MemData  (MemData),
    .MemAddr  (MemAddr),
    .IR       (IR),
    .IRValid  (IRValid),
    .Busy     (Busy),
    .PC       (PC),
    .Wrap     (Wrap),
    .FsmState (FsmState)
  );

  // ---------------- clock / reset ----------------
  initial MClock = 1'b0;
  always #5 MClock = ~MClock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- memory model ----------------
  logic [DATA_W-1:0] mem [32];
  always @(posedge MClock) MemData <= mem[MemAddr];

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic irvalid_prev = 1'b0;
  always begin
    @(posedge MClock);
    #1;
    if (IRValid && !irvalid_prev) begin
      if (exp_q.size() == 0) chk("unexpected_capture", 32'(IR), 32'hDEAD_BEEF);
      else chk("ir_capture", 32'(IR), 32'(exp_q.pop_front()));
    end
    irvalid_prev = IRValid;
  end

  // ---------------- driver tasks ----------------
  logic [ADDR_W-1:0] pc_m;
  logic [DATA_W-1:0] last_ir;

  task automatic tick();
    @(posedge MClock);
    #1;
  endtask

  task automatic do_fetch();
    Fetch = 1'b1;
    exp_q.push_back(mem[pc_m]);
    tick();
    Fetch = 1'b0;
    chk("fetch_busy_addr", 32'(Busy), 32'd1);
    tick();
    chk("fetch_state_capt", 32'(FsmState), 32'd2);
    tick();
    last_ir = mem[pc_m];
    pc_m    = pc_m + 5'd1;
    chk("fetch_irvalid", 32'(IRValid), 32'd1);
    chk("fetch_pc", 32'(PC), 32'(pc_m));
    chk("fetch_memaddr", 32'(MemAddr), 32'(pc_m));
    chk("fetch_idle", 32'(Busy), 32'd0);
  endtask

  task automatic do_load(input logic [ADDR_W-1:0] a);
    Load     = 1'b1;
    LoadAddr = a;
    tick();
    Load = 1'b0;
    pc_m = a;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_pc"},      32'(PC),       32'd0);
    chk({tag, "_memaddr"}, 32'(MemAddr),  32'd0);
    chk({tag, "_ir"},      32'(IR),       32'd0);
    chk({tag, "_irvalid"}, 32'(IRValid),  32'd0);
    chk({tag, "_busy"},    32'(Busy),     32'd0);
    chk({tag, "_wrap"},    32'(Wrap),     32'd0);
    chk({tag, "_state"},   32'(FsmState), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom_range(0, 16'hFFFF));
    mem[0] = 16'h0040;
    mem[1] = 16'h1111;
    mem[2] = 16'h2222;
    mem[3] = 16'h3333;
    Reset = 1'b1; Fetch = 1'b0; Load = 1'b0; LoadAddr = '0;
    pc_m = '0; last_ir = '0;
    tick(); tick();
    chk_reset_values("reset");
    Reset = 1'b0;
    tick();

    // 1: single fetch from address 0
    do_fetch();
    chk("t1_ir", 32'(IR), 32'h0040);

    // 2: Fetch held high, one capture every 3 cycles
    Fetch = 1'b1;
    for (int i = 1; i <= 3; i++) exp_q.push_back(mem[i]);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("t2_busy", 32'(Busy), (i % 3 == 2) ? 32'd0 : 32'd1);
    end
    Fetch = 1'b0;
    pc_m = 5'd4;
    last_ir = mem[3];
    chk("t2_ir", 32'(IR), 32'h3333);
    chk("t2_pc", 32'(PC), 32'd4);

    // 3: load 31, fetch, PC wraps to 0 with a one-cycle Wrap pulse
    do_load(5'd31);
    chk("t3_load_pc", 32'(PC), 32'd31);
    chk("t3_load_irvalid", 32'(IRValid), 32'd0);
    chk("t3_load_nowrap", 32'(Wrap), 32'd0);
    do_fetch();
    chk("t3_ir", 32'(IR), 32'(mem[31]));
    chk("t3_wrap", 32'(Wrap), 32'd1);
    tick();
    chk("t3_wrap_pulse", 32'(Wrap), 32'd0);
    chk("t3_irvalid_hold", 32'(IRValid), 32'd1);

    // 4a: Load during ADDR aborts the fetch
    Fetch = 1'b1;
    tick();
    Fetch = 1'b0;
    chk("t4a_state_addr", 32'(FsmState), 32'd1);
    do_load(5'd10);
    chk("t4a_pc", 32'(PC), 32'd10);
    chk("t4a_irvalid", 32'(IRValid), 32'd0);
    chk("t4a_ir_unchanged", 32'(IR), 32'(last_ir));
    chk("t4a_state", 32'(FsmState), 32'd0);
    do_fetch();
    chk("t4a_ir", 32'(IR), 32'(mem[10]));

    // 4b: Load during CAPT aborts and discards MemData
    Fetch = 1'b1;
    tick();
    Fetch = 1'b0;
    tick();
    chk("t4b_state_capt", 32'(FsmState), 32'd2);
    do_load(5'd20);
    chk("t4b_pc", 32'(PC), 32'd20);
    chk("t4b_irvalid", 32'(IRValid), 32'd0);
    chk("t4b_ir_unchanged", 32'(IR), 32'(last_ir));
    chk("t4b_state", 32'(FsmState), 32'd0);
    do_fetch();
    chk("t4b_ir", 32'(IR), 32'(mem[20]));

    // 5: Load and Fetch together in IDLE -> only the load happens
    Fetch = 1'b1;
    do_load(5'd7);
    Fetch = 1'b0;
    chk("t5_pc", 32'(PC), 32'd7);
    chk("t5_busy", 32'(Busy), 32'd0);
    tick();
    chk("t5_still_idle", 32'(Busy), 32'd0);
    do_load(5'd0);
    chk("t5_load0_nowrap", 32'(Wrap), 32'd0);
    chk("t5_load0_pc", 32'(PC), 32'd0);

    // 6: async reset between edges while in CAPT
    do_load(5'd12);
    Fetch = 1'b1;
    tick();
    Fetch = 1'b0;
    tick();
    chk("t6_state_capt", 32'(FsmState), 32'd2);
    #2;
    Reset = 1'b1;
    #1;
    chk_reset_values("t6_async");
    tick();
    Reset = 1'b0;
    pc_m = '0;
    tick();
    chk_reset_values("t6_release");
    do_fetch();
    chk("t6_ir", 32'(IR), 32'h0040);

    tick(); tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
